// File: rtl/axil_pkg.sv
// ---------------------------------------------------------------------------
// axil_pkg
// Types and constants shared by the AXI4-Lite command master:
//   - axil_state_e : FSM state encoding (IDLE, WR, WR_B, RD_A, RD_R, RSP)
//   - RESP_*       : AXI response codes OKAY / EXOKAY / SLVERR / DECERR
//   - AXI_PROT     : fixed protection attribute driven on AWPROT/ARPROT
//   - data_w_legal : legality check for the data-width parameter (32 or 64)
// ---------------------------------------------------------------------------
package axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_WR_B = 3'd2,
    ST_RD_A = 3'd3,
    ST_RD_R = 3'd4,
    ST_RSP  = 3'd5
  } axil_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT = 3'b000;

  function automatic bit data_w_legal(input int w);
    return (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/axil_wdog.sv
// ---------------------------------------------------------------------------
// axil_wdog
// Loadable down-counter used as a per-state watchdog. A load pulse reloads
// the count; otherwise it decrements and saturates at zero. 'expired' is high
// whenever the count is zero.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   load, load_val : synchronous reload request and value
//   expired        : count has reached zero
// ---------------------------------------------------------------------------
module axil_wdog #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/axil_cmd_master.sv
// ---------------------------------------------------------------------------
// axil_cmd_master
// Turns single read/write commands into AXI4-Lite transactions and returns
// one response pulse per command.
// Optional feature macro: AXIL_TIMEOUT_EN (per-state watchdog abort).
// Ports:
//   CLK, RST                    : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         : command handshake, ready only in IDLE
//   cmd_wr/addr/wdata/wstrb     : command payload, latched on acceptance
//   rsp_valid                   : one-cycle completion pulse
//   rsp_rdata/rsp_resp          : captured RDATA (held) and BRESP/RRESP
//   rsp_timeout                 : aborted by watchdog (0 without the macro)
//   M_AXI_AW*/W*/B*/AR*/R*      : AXI4-Lite master channels
//   dbg_state                   : current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a valid, once raised, stays high with stable payload until that
// edge and is removed on the edge itself.
// ---------------------------------------------------------------------------
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [2:0]          M_AXI_AWPROT,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic [2:0]          M_AXI_ARPROT,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY,
  output logic [2:0]          dbg_state
);

  localparam int STRB_W = DATA_W / 8;

  if (!data_w_legal(DATA_W) || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("axil_cmd_master: DATA_W must be 32 or 64 and TIMEOUT_CYC >= 1");
  end

  axil_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic                aw_hs, w_hs;

  assign aw_hs = awvalid_q && M_AXI_AWREADY;
  assign w_hs  = wvalid_q && M_AXI_WREADY;

`ifdef AXIL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic rsp_timeout_q, rsp_timeout_d;
  logic wd_load, wd_expired;

  // Reload on every state change so each wait state gets a full budget;
  // expiry then lands on the TIMEOUT_CYC-th cycle spent in that state.
  assign wd_load = (state_d != state_q);

  axil_wdog #(.CNT_W(CNT_W)) u_wdog (
    .clk      (CLK),
    .rst      (RST),
    .load     (wd_load),
    .load_val (CNT_W'(TIMEOUT_CYC - 1)),
    .expired  (wd_expired)
  );
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
`ifdef AXIL_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_wr) begin
            state_d   = ST_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RD_A;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        // Leave once both channels are done, whether they finished earlier
        // (valid already low) or finish on this edge.
        if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) begin
          state_d  = ST_WR_B;
          bready_d = 1'b1;
        end
      end
      ST_WR_B: begin
        if (M_AXI_BVALID) begin
          state_d    = ST_RSP;
          bready_d   = 1'b0;
          rsp_resp_d = M_AXI_BRESP;
`ifdef AXIL_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end
      end
      ST_RD_A: begin
        if (M_AXI_ARREADY) begin
          state_d   = ST_RD_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      ST_RD_R: begin
        if (M_AXI_RVALID) begin
          state_d     = ST_RSP;
          rready_d    = 1'b0;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
`ifdef AXIL_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end
      end
      ST_RSP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef AXIL_TIMEOUT_EN
    // A handshake completing on the expiry edge wins; abort only when the
    // FSM is still stuck in its wait state.
    if (wd_expired && (state_d == state_q) &&
        (state_q == ST_WR || state_q == ST_WR_B ||
         state_q == ST_RD_A || state_q == ST_RD_R)) begin
      state_d       = ST_RSP;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_rdata_d   = '0;
      rsp_resp_d    = RESP_SLVERR;
      rsp_timeout_d = 1'b1;
    end
`endif

    rsp_valid_d = (state_d == ST_RSP);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
`ifdef AXIL_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
`ifdef AXIL_TIMEOUT_EN
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

`ifdef AXIL_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready     = (state_q == ST_IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = AXI_PROT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = AXI_PROT;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_axil_cmd_master
// Directed, table-driven bench for axil_cmd_master (32-bit address/data,
// TIMEOUT_CYC = 16). Each table row is one command plus the slave's per-
// channel ready/response delays and the hand-computed response and latency.
// Hand-written sequences cover reset mid-read and, when AXIL_TIMEOUT_EN is
// defined, the B-channel timeout.
// ---------------------------------------------------------------------------
module tb_axil_cmd_master;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready = 1'b0;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready = 1'b0;
  logic [1:0]    bresp = 2'b00;
  logic          bvalid = 1'b0;
  logic          bready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = 2'b00;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [2:0]    dbg_state;

  axil_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_miss   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly;   // AWREADY delay (cycles of AWVALID before ready)
    int          w_dly;    // WREADY delay
    int          ar_dly;   // ARREADY delay
    int          rsp_dly;  // BVALID/RVALID delay after address/data phase
    logic [1:0]  resp;     // BRESP/RRESP returned by slave
    logic [31:0] rdata;    // RDATA returned by slave
    logic [31:0] exp_rdata;
    int          exp_lat;  // cycles from accept edge to rsp_valid
  } vec_t;

  vec_t tbl[7];

  // Drive one command and act as the slave until the response has been seen.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc, aw_seen, w_seen, ar_seen;
    int aw_hs, w_hs, ar_hs, b_hs, r_hs, rsp_cnt, rsp_cyc, b_wait, r_wait;
    bit b_drop, r_drop, bound_hit;
    logic [1:0]  got_resp;
    logic [31:0] got_rdata;
    logic        got_to;
    string tag;
    tag = $sformatf("v%0d", idx);
    {aw_seen, w_seen, ar_seen, aw_hs, w_hs, ar_hs, b_hs, r_hs} = '0;
    {rsp_cnt, rsp_cyc, b_wait, r_wait} = '0;
    {b_drop, r_drop} = '0;
    got_resp = 2'b00; got_rdata = '0; got_to = 1'b0;

    @(negedge CLK);
    cmd_valid = 1'b1; cmd_wr = v.wr; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    chk({tag, "_cmd_ready_idle"}, cmd_ready, 1);
    @(posedge CLK);
    // Junk command held on the port while busy: it must be ignored.
    #1;
    cmd_wr = ~v.wr; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_wstrb = ~v.wstrb;

    bound_hit = 1'b1;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(negedge CLK);
      if (cyc == 1) chk({tag, "_cmd_ready_busy"}, cmd_ready, 0);
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_cyc   = cyc;
        got_resp  = rsp_resp;
        got_rdata = rsp_rdata;
        got_to    = rsp_timeout;
        cmd_valid = 1'b0;
      end
      // B channel: only after both AW and W handshakes have happened.
      if (b_drop) begin bvalid = 1'b0; b_drop = 1'b0; end
      if (v.wr && aw_hs > 0 && w_hs > 0 && !bvalid && b_hs == 0) begin
        if (b_wait >= v.rsp_dly) begin bvalid = 1'b1; bresp = v.resp; end
        else b_wait++;
      end
      if (bvalid && bready) begin b_hs++; b_drop = 1'b1; end
      // R channel: only after the AR handshake.
      if (r_drop) begin rvalid = 1'b0; r_drop = 1'b0; end
      if (!v.wr && ar_hs > 0 && !rvalid && r_hs == 0) begin
        if (r_wait >= v.rsp_dly) begin rvalid = 1'b1; rdata = v.rdata; rresp = v.resp; end
        else r_wait++;
      end
      if (rvalid && rready) begin r_hs++; r_drop = 1'b1; end
      // AW / W / AR: ready stays high once the delay has passed, so a valid
      // that fails to drop would be counted as a second handshake.
      if (awvalid) begin
        chk({tag, "_awaddr"}, awaddr, v.addr);
        awready = (aw_seen >= v.aw_dly); aw_seen++;
        if (awready) aw_hs++;
      end else awready = 1'b0;
      if (wvalid) begin
        chk({tag, "_wdata"}, wdata, v.wdata);
        chk({tag, "_wstrb"}, wstrb, v.wstrb);
        wready = (w_seen >= v.w_dly); w_seen++;
        if (wready) w_hs++;
      end else wready = 1'b0;
      if (arvalid) begin
        chk({tag, "_araddr"}, araddr, v.addr);
        arready = (ar_seen >= v.ar_dly); ar_seen++;
        if (arready) ar_hs++;
      end else arready = 1'b0;
      if (rsp_cnt > 0 && cyc >= rsp_cyc + 2) begin bound_hit = 1'b0; break; end
    end
    cmd_valid = 1'b0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; rvalid = 1'b0;

    if (bound_hit) $display("FAIL %s_timeout: no response within 60 cycles", tag);
    chk({tag, "_bound"}, bound_hit, 0);
    chk({tag, "_latency"}, rsp_cyc, v.exp_lat);
    chk({tag, "_rsp_pulses"}, rsp_cnt, 1);
    chk({tag, "_rsp_resp"}, got_resp, v.resp);
    exp_q.push_back(v.exp_rdata);
    chk({tag, "_rsp_rdata"}, got_rdata, exp_q.pop_front());
    chk({tag, "_rsp_timeout"}, got_to, 0);
    chk({tag, "_aw_hs"}, aw_hs, v.wr ? 1 : 0);
    chk({tag, "_w_hs"}, w_hs, v.wr ? 1 : 0);
    chk({tag, "_b_hs"}, b_hs, v.wr ? 1 : 0);
    chk({tag, "_ar_hs"}, ar_hs, v.wr ? 0 : 1);
    chk({tag, "_r_hs"}, r_hs, v.wr ? 0 : 1);
    chk({tag, "_cmd_ready_end"}, cmd_ready, 1);
  endtask

  // ---------------- main test ----------------
  initial begin : main
    int rsp_seen;
    // wr addr wdata wstrb aw w ar dly resp rdata exp_rdata lat
    tbl[0] = '{1'b1, 32'h0000_0004, 32'h0000_9AE5, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 3};
    tbl[1] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'h3, 2, 0, 0, 1, 2'b10, 32'h0, 32'h0, 6};
    tbl[2] = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 0, 4, 2'b00, 32'h1234_5678, 32'h1234_5678, 7};
    tbl[3] = '{1'b0, 32'h0000_0014, 32'h0, 4'h0, 0, 0, 1, 0, 2'b11, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 4};
    tbl[4] = '{1'b1, 32'h0000_0020, 32'h5555_AAAA, 4'hC, 0, 3, 0, 0, 2'b01, 32'h0, 32'hA5A5_0F0F, 6};
    tbl[5] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 0, 0, 2, 2, 2'b00, 32'h0000_0001, 32'h0000_0001, 7};
    tbl[6] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'h1, 1, 1, 0, 2, 2'b11, 32'h0, 32'h0000_0001, 6};

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("prot_aw", awprot, 0);
    chk("prot_ar", arprot, 0);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Reset while waiting in RD_R: everything drops at once, no response.
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h30;
    @(posedge CLK);
    #1 cmd_valid = 1'b0; arready = 1'b1;
    @(negedge CLK);
    chk("rr_arvalid", arvalid, 1);
    @(negedge CLK);
    arready = 1'b0;
    chk("rr_rready", rready, 1);
    #2 RST = 1'b1;
    #1;
    chk("rr_async_rready", rready, 0);
    chk("rr_async_arvalid", arvalid, 0);
    chk("rr_async_rsp_valid", rsp_valid, 0);
    chk("rr_async_rdata", rsp_rdata, 0);
    chk("rr_async_resp", rsp_resp, 0);
    chk("rr_async_cmd_ready", cmd_ready, 1);
    @(negedge CLK);
    RST = 1'b0;
    rsp_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (rsp_valid) rsp_seen++;
    end
    chk("rr_no_rsp", rsp_seen, 0);
    run_vec(tbl[0], 10);
    run_vec(tbl[2], 12);

`ifdef AXIL_TIMEOUT_EN
    begin : timeout_seq
      int b_cyc, to_cyc;
      logic to_flag;
      logic [1:0] to_resp;
      logic [31:0] to_rdata;
      b_cyc = 0; to_cyc = 0; to_flag = 0; to_resp = 0; to_rdata = '1;
      @(negedge CLK);
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h40;
      cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
      @(posedge CLK);
      #1 cmd_valid = 1'b0; awready = 1'b1; wready = 1'b1;
      for (int c = 1; c <= 40; c++) begin
        @(negedge CLK);
        if (bready) b_cyc++;
        if (rsp_valid) begin
          to_cyc = c; to_flag = rsp_timeout; to_resp = rsp_resp; to_rdata = rsp_rdata;
          break;
        end
      end
      awready = 1'b0; wready = 1'b0;
      chk("to_bready_cycles", b_cyc, 16);
      chk("to_latency", to_cyc, 18);
      chk("to_flag", to_flag, 1);
      chk("to_resp", to_resp, 2'b10);
      chk("to_rdata", to_rdata, 0);
      @(negedge CLK);
      chk("to_idle", cmd_ready, 1);
      run_vec(tbl[0], 20);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 Param ADDR_W, default 32, byte address width of the AXI4-Lite and command ports.
REQ-002 Param DATA_W, default 32, data width; legal values 32 and 64 only.
REQ-003 Param TIMEOUT_CYC, default 256, cycles allowed per wait state before abort.
REQ-004 CLK  in  1  single clock; all logic on rising edge.
REQ-005 RST  in  1  reset, asynchronous and active-high.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-007 cmd_wr  in  1  1 = write, 0 = read.
REQ-008 cmd_addr/cmd_wdata/cmd_wstrb  in  ADDR_W/DATA_W/DATA_W/8  command payload.
REQ-009 rsp_valid  out  1  one-cycle pulse, transaction complete.
REQ-010 rsp_rdata/rsp_resp/rsp_timeout  out  DATA_W/2/1  read data, BRESP or RRESP, abort flag.
REQ-011 M_AXI_AW*, W*, B*, AR*, R*: full AXI4-Lite master set; PROT is 3'b000; WSTRB is DATA_W/8 bits.

Function
REQ-012 FSM states: IDLE, WR (AW+W), WR_B, RD_A, RD_R, RSP.
REQ-013 cmd_ready shall be high only in IDLE; cmd_valid&&cmd_ready latches payload and moves to WR or RD_A.
REQ-014 AWVALID and WVALID shall both assert the cycle after acceptance; there is no AW-before-W ordering.
REQ-015 AWVALID and WVALID shall each drop the cycle after their own handshake, independently; payload is held stable while valid.
REQ-016 Same-cycle AW and W handshakes shall move WR to WR_B on the next edge; otherwise WR exits after the later handshake.
REQ-017 BREADY shall be high only in WR_B; BVALID&&BREADY captures BRESP and moves to RSP.
REQ-018 ARVALID shall be high in RD_A until handshake; RREADY shall be high only in RD_R; RVALID&&RREADY captures RDATA/RRESP and moves to RSP.
REQ-019 RSP shall pulse rsp_valid for exactly one cycle and then return to IDLE; rsp_rdata holds until the next capture.
REQ-020 Zero-wait-slave latency: write cmd accept to rsp_valid 3 cycles; read cmd accept to rsp_valid 3 cycles.
REQ-021 rsp_resp passes SLVERR/DECERR unchanged; the block performs no retry.
REQ-022 cmd_valid while busy shall be ignored (cmd_ready=0), with no effect on the current transfer.

Reset
REQ-023 RST shall force IDLE; all *VALID, BREADY, RREADY, rsp_valid and rsp_timeout = 0; rsp_rdata = 0; rsp_resp = 2'b00.
REQ-024 RST mid-transaction shall drop all AXI valids/readys immediately (async) and issue no rsp_valid for the aborted command.

Configuration
REQ-025 Macro AXIL_TIMEOUT_EN: when defined, a counter resets on each state entry, and reaching TIMEOUT_CYC in WR, WR_B, RD_A or RD_R deasserts all channel signals and goes to RSP with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
REQ-026 Without AXIL_TIMEOUT_EN, the counter is not synthesised, rsp_timeout is tied 0, and the block waits indefinitely.

Structure
REQ-027 Shared package axil_pkg holds the state encoding, the response constants OKAY/EXOKAY/SLVERR/DECERR, and the legal DATA_W check.
REQ-028 One sub-module, axil_wdog (loadable down-counter with expire flag), is instantiated only under AXIL_TIMEOUT_EN.

Verification
REQ-029 Write addr 0x04, data 0x9AE5, strb 0xF, slave ready immediately -> AW/W same cycle, rsp_valid 3 cycles after accept, rsp_resp=00.
REQ-030 Write where slave raises WREADY 2 cycles before AWREADY -> WVALID drops first, AWVALID holds, and exactly one BREADY handshake occurs.
REQ-031 Read addr 0x10, slave returns 0x12345678 OKAY after 4-cycle RVALID delay -> rsp_rdata=0x12345678, rsp_resp=00, one rsp pulse.
REQ-032 Read returning RRESP=2'b11 -> rsp_resp=11, no retry, next command accepted.
REQ-033 AXIL_TIMEOUT_EN, TIMEOUT_CYC=16, BVALID never asserted -> rsp_timeout=1, rsp_resp=10 at cycle 16 of WR_B, then IDLE.
REQ-034 RST asserted during RD_R, then back-to-back commands -> outputs at reset values, no rsp_valid, and the next command completes normally.
